// File: rtl/rowbias_shuffler.sv
// Per-row permutation generator: Fisher-Yates shuffle of a one-hot identity pool,
// driven by a 16-bit Galois LFSR, published for rowbias to index by one-hot rqindex.
module rowbias_shuffler #(
   parameter int unsigned w      = 9,
   parameter int unsigned LFSR_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pool_valid,
   output logic [w*w-1:0]    pool
);

   localparam int unsigned       IW         = (w > 1) ? $clog2(w) : 1;
   localparam logic [IW-1:0]     IDX_TOP    = IW'(w - 1);
   localparam logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(16'hB400);
   localparam logic [LFSR_W-1:0] LFSR_RESET = LFSR_W'(16'hACE1);

   typedef enum logic [1:0] {StIdle, StInit, StShuffle, StFin} state_e;

   state_e            state_q, state_d;
   logic [w-1:0]      pool_q [w];
   logic [w-1:0]      pool_d [w];
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     mask, cand;
   logic              accept;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic              busy_d, done_d, pool_valid_d;

   function automatic logic [w-1:0] onehot(input int unsigned i);
      logic [w-1:0] one;
      one    = '0;
      one[0] = 1'b1;
      return one << i;
   endfunction

   // Smear idx rightwards to get the smallest 2^k-1 covering it.
   always_comb begin
      mask = idx_q;
      for (int unsigned i = 0; i < IW; i++) begin
         mask = mask | (mask >> 1);
      end
   end

   assign cand      = lfsr_q[IW-1:0] & mask;
   assign accept    = (cand <= idx_q);
   assign lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

   always_comb begin
      state_d = state_q;
      pool_d  = pool_q;
      idx_d   = idx_q;
      lfsr_d  = lfsr_q;
      unique case (state_q)
         StIdle: begin
            if (seed_load) begin
               lfsr_d = (seed == '0) ? LFSR_RESET : seed;
            end
            if (start) begin
               state_d = StInit;
            end
         end
         StInit: begin
            for (int unsigned i = 0; i < w; i++) begin
               pool_d[i] = onehot(i);
            end
            idx_d   = IDX_TOP;
            state_d = (w == 1) ? StFin : StShuffle;
         end
         StShuffle: begin
            lfsr_d = lfsr_step;
            if (accept) begin
               // cand == idx degenerates to a self-swap, which leaves the pool unchanged.
               pool_d[idx_q] = pool_q[cand];
               pool_d[cand]  = pool_q[idx_q];
               idx_d         = idx_q - IW'(1);
               if (idx_q == IW'(1)) begin
                  state_d = StFin;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Status flags are registered from the current state, so they trail it by one cycle.
   always_comb begin
      busy_d       = (state_q == StInit) || (state_q == StShuffle);
      done_d       = (state_q == StFin);
      pool_valid_d = !busy_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= IDX_TOP;
         lfsr_q     <= LFSR_RESET;
         busy       <= 1'b0;
         done       <= 1'b0;
         pool_valid <= 1'b1;
         for (int unsigned i = 0; i < w; i++) begin
            pool_q[i] <= onehot(i);
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lfsr_q     <= lfsr_d;
         busy       <= busy_d;
         done       <= done_d;
         pool_valid <= pool_valid_d;
         pool_q     <= pool_d;
      end
   end

   for (genvar i = 0; i < w; i++) begin : g_pool
      assign pool[i*w +: w] = pool_q[i];
   end

endmodule
